// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command controller: FSM states,
// frame header default, status nibble and ALU unit-select codes.
package alu_cmd_ctrl_pkg;

    localparam int OPER_W = 16;
    localparam int RES_W  = 17;
    localparam int WAIT_W = 3;

    localparam logic [7:0] HEADER_DEF = 8'hCC;
    localparam logic [3:0] STATUS_NIB = 4'hA;

    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_CMP   = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RX_AL = 4'd1,
        ST_RX_AH = 4'd2,
        ST_RX_BL = 4'd3,
        ST_RX_BH = 4'd4,
        ST_RX_FN = 4'd5,
        ST_EXEC  = 4'd6,
        ST_TX_ST = 4'd7,
        ST_TX_LO = 4'd8,
        ST_TX_HI = 4'd9
    } state_e;

    function automatic logic [7:0] status_byte(input logic err, input logic res_msb);
        return {STATUS_NIB, 2'b00, err, res_msb};
    endfunction

endpackage

// File: rtl/alu_result_sel.sv
// Selects the result of the ALU unit addressed by sel and flags an error when
// that unit's valid flag is low; an error forces the result to zero.
module alu_result_sel
    import alu_cmd_ctrl_pkg::*;
(
    input  logic [1:0]        i_sel,
    input  logic [OPER_W-1:0] i_arith_out,
    input  logic              i_carry_out,
    input  logic [RES_W-1:0]  i_logic_out,
    input  logic [1:0]        i_cmp_out,
    input  logic [OPER_W-1:0] i_shift_out,
    input  logic              i_arith_flag,
    input  logic              i_logic_flag,
    input  logic              i_cmp_flag,
    input  logic              i_shift_flag,
    output logic [RES_W-1:0]  o_res,
    output logic              o_err
);

    logic [RES_W-1:0] w_raw;
    logic             w_flag;

    // Unit multiplexer with flag check
    always_comb begin
        w_raw  = {RES_W{1'b0}};
        w_flag = 1'b0;
        case (i_sel)
            SEL_ARITH: begin
                w_raw  = {i_carry_out, i_arith_out};
                w_flag = i_arith_flag;
            end
            SEL_LOGIC: begin
                w_raw  = i_logic_out;
                w_flag = i_logic_flag;
            end
            SEL_CMP: begin
                w_raw  = {15'd0, i_cmp_out};
                w_flag = i_cmp_flag;
            end
            SEL_SHIFT: begin
                w_raw  = {1'b0, i_shift_out};
                w_flag = i_shift_flag;
            end
            default: begin
                w_raw  = {RES_W{1'b0}};
                w_flag = 1'b0;
            end
        endcase
        o_err = ~w_flag;
        if (w_flag) begin
            o_res = w_raw;
        end else begin
            o_res = {RES_W{1'b0}};
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command controller: assembles 6-byte frames into ALU operands,
// waits for the ALU latency, then returns a 3-byte status/result response.
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter logic [7:0] HEADER  = HEADER_DEF,
    parameter int         ALU_LAT = 1
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic [OPER_W-1:0] A,
    output logic [OPER_W-1:0] B,
    output logic [3:0]        ALU_FUN,
    input  logic [OPER_W-1:0] Arith_OUT,
    input  logic              Carry_OUT,
    input  logic [RES_W-1:0]  Logic_OUT,
    input  logic [1:0]        CMP_OUT,
    input  logic [OPER_W-1:0] SHIFT_OUT,
    input  logic              Arith_Flag,
    input  logic              Logic_Flag,
    input  logic              CMP_Flag,
    input  logic              SHIFT_Flag,
    output logic              BUSY
);

    state_e              r_state;
    state_e              w_next;
    logic                w_rx_state;
    logic                w_rx_fire;
    logic                w_tx_fire;
    logic [OPER_W-1:0]   r_stg_a;
    logic [OPER_W-1:0]   r_stg_b;
    logic [OPER_W-1:0]   r_a;
    logic [OPER_W-1:0]   r_b;
    logic [3:0]          r_fun;
    logic [WAIT_W-1:0]   r_wait;
    logic [RES_W-1:0]    r_res;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic [RES_W-1:0]    w_res;
    logic                w_err;

    alu_result_sel u_sel (
        .i_sel        (r_fun[3:2]),
        .i_arith_out  (Arith_OUT),
        .i_carry_out  (Carry_OUT),
        .i_logic_out  (Logic_OUT),
        .i_cmp_out    (CMP_OUT),
        .i_shift_out  (SHIFT_OUT),
        .i_arith_flag (Arith_Flag),
        .i_logic_flag (Logic_Flag),
        .i_cmp_flag   (CMP_Flag),
        .i_shift_flag (SHIFT_Flag),
        .o_res        (w_res),
        .o_err        (w_err)
    );

    // Gated by RST so the port reads 0 while reset is held, yet is high in IDLE right after.
    assign RX_READY  = w_rx_state & ~RST;
    assign w_rx_fire = RX_VALID & w_rx_state;
    assign w_tx_fire = r_tx_valid & TX_READY;
    assign TX_DATA   = r_tx_data;
    assign TX_VALID  = r_tx_valid;
    assign A         = r_a;
    assign B         = r_b;
    assign ALU_FUN   = r_fun;
    assign BUSY      = (r_state != ST_IDLE);

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and RX-ready decode
    always_comb begin
        w_next     = r_state;
        w_rx_state = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rx_state = 1'b1;
                if (w_rx_fire && (RX_DATA == HEADER)) w_next = ST_RX_AL;
                else                                  w_next = ST_IDLE;
            end
            ST_RX_AL: begin
                w_rx_state = 1'b1;
                if (w_rx_fire) w_next = ST_RX_AH; else w_next = r_state;
            end
            ST_RX_AH: begin
                w_rx_state = 1'b1;
                if (w_rx_fire) w_next = ST_RX_BL; else w_next = r_state;
            end
            ST_RX_BL: begin
                w_rx_state = 1'b1;
                if (w_rx_fire) w_next = ST_RX_BH; else w_next = r_state;
            end
            ST_RX_BH: begin
                w_rx_state = 1'b1;
                if (w_rx_fire) w_next = ST_RX_FN; else w_next = r_state;
            end
            ST_RX_FN: begin
                w_rx_state = 1'b1;
                if (w_rx_fire) w_next = ST_EXEC; else w_next = r_state;
            end
            ST_EXEC: begin
                if (r_wait == {WAIT_W{1'b0}}) w_next = ST_TX_ST; else w_next = r_state;
            end
            ST_TX_ST: begin
                if (w_tx_fire) w_next = ST_TX_LO; else w_next = r_state;
            end
            ST_TX_LO: begin
                if (w_tx_fire) w_next = ST_TX_HI; else w_next = r_state;
            end
            ST_TX_HI: begin
                if (w_tx_fire) w_next = ST_IDLE; else w_next = r_state;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame staging, operand registers, wait counter and TX byte register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stg_a    <= {OPER_W{1'b0}};
            r_stg_b    <= {OPER_W{1'b0}};
            r_a        <= {OPER_W{1'b0}};
            r_b        <= {OPER_W{1'b0}};
            r_fun      <= 4'd0;
            r_wait     <= {WAIT_W{1'b0}};
            r_res      <= {RES_W{1'b0}};
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RX_AL: if (w_rx_fire) r_stg_a[7:0]  <= RX_DATA;
                ST_RX_AH: if (w_rx_fire) r_stg_a[15:8] <= RX_DATA;
                ST_RX_BL: if (w_rx_fire) r_stg_b[7:0]  <= RX_DATA;
                ST_RX_BH: if (w_rx_fire) r_stg_b[15:8] <= RX_DATA;
                ST_RX_FN: begin
                    if (w_rx_fire) begin
                        r_a    <= r_stg_a;
                        r_b    <= r_stg_b;
                        r_fun  <= RX_DATA[3:0];
                        r_wait <= WAIT_W'(ALU_LAT);
                    end
                end
                ST_EXEC: begin
                    if (r_wait == {WAIT_W{1'b0}}) begin
                        r_res      <= w_res;
                        r_tx_data  <= status_byte(w_err, w_res[16]);
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                ST_TX_ST: if (w_tx_fire) r_tx_data <= r_res[7:0];
                ST_TX_LO: if (w_tx_fire) r_tx_data <= r_res[15:8];
                ST_TX_HI: if (w_tx_fire) r_tx_valid <= 1'b0;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed and randomized bench for alu_cmd_ctrl with a small registered ALU
// model and a reference model of the expected 3-byte response.
module tb_alu_cmd_ctrl;

    localparam int LAT = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_DATA = 8'd0;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic [15:0] A, B;
    logic [3:0]  ALU_FUN;
    logic [15:0] Arith_OUT;
    logic        Carry_OUT;
    logic [16:0] Logic_OUT;
    logic [1:0]  CMP_OUT;
    logic [15:0] SHIFT_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic        BUSY;

    bit          flag_kill = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_q[$];

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(.HEADER(8'hCC), .ALU_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag),
        .SHIFT_Flag(SHIFT_Flag), .BUSY(BUSY)
    );

    // Stand-in ALU: one registered stage from operand inputs to outputs.
    always @(posedge CLK) begin
        case (ALU_FUN[1:0])
            2'd0: {Carry_OUT, Arith_OUT} <= {1'b0, A} + {1'b0, B};
            2'd1: {Carry_OUT, Arith_OUT} <= {1'b0, A} - {1'b0, B};
            2'd2: {Carry_OUT, Arith_OUT} <= {1'b0, A} + {1'b0, B} + 17'd1;
            default: {Carry_OUT, Arith_OUT} <= {1'b0, A} - 17'd1;
        endcase
        case (ALU_FUN[1:0])
            2'd0: Logic_OUT <= {A[15] ^ B[15], A & B};
            2'd1: Logic_OUT <= {A[15] ^ B[15], A | B};
            2'd2: Logic_OUT <= {A[15] ^ B[15], ~(A & B)};
            default: Logic_OUT <= {A[15] ^ B[15], ~(A | B)};
        endcase
        case (ALU_FUN[1:0])
            2'd0: CMP_OUT <= (A == B) ? 2'd1 : 2'd0;
            2'd1: CMP_OUT <= (A > B) ? 2'd2 : 2'd0;
            2'd2: CMP_OUT <= (A < B) ? 2'd3 : 2'd0;
            default: CMP_OUT <= 2'd0;
        endcase
        case (ALU_FUN[1:0])
            2'd0: SHIFT_OUT <= A >> 1;
            2'd1: SHIFT_OUT <= A << 1;
            2'd2: SHIFT_OUT <= B >> 1;
            default: SHIFT_OUT <= B << 1;
        endcase
        Arith_Flag <= !flag_kill && (ALU_FUN[3:2] == 2'd0);
        Logic_Flag <= !flag_kill && (ALU_FUN[3:2] == 2'd1);
        CMP_Flag   <= !flag_kill && (ALU_FUN[3:2] == 2'd2);
        SHIFT_Flag <= !flag_kill && (ALU_FUN[3:2] == 2'd3);
    end

    // Collects every TX byte that is actually transferred.
    always @(negedge CLK) begin
        if (!RST && TX_VALID && TX_READY) tx_q.push_back(TX_DATA);
    end

    // Expected response bytes {status, res_lo, res_hi} from plain arithmetic.
    function automatic logic [23:0] ref_resp(input int a, input int b, input int f, input bit kill);
        int r;
        int sub;
        sub = f % 4;
        case (f / 4)
            0: begin
                if (sub == 0)      r = a + b;
                else if (sub == 1) r = (a - b) & 32'h1FFFF;
                else if (sub == 2) r = a + b + 1;
                else               r = (a - 1) & 32'h1FFFF;
            end
            1: begin
                if (sub == 0)      r = a & b;
                else if (sub == 1) r = a | b;
                else if (sub == 2) r = (~(a & b)) & 32'hFFFF;
                else               r = (~(a | b)) & 32'hFFFF;
                if ((a >= 32768) != (b >= 32768)) r = r + 65536;
            end
            2: begin
                if (sub == 0)      r = (a == b) ? 1 : 0;
                else if (sub == 1) r = (a > b) ? 2 : 0;
                else if (sub == 2) r = (a < b) ? 3 : 0;
                else               r = 0;
            end
            default: begin
                if (sub == 0)      r = a / 2;
                else if (sub == 1) r = (a * 2) % 65536;
                else if (sub == 2) r = b / 2;
                else               r = (b * 2) % 65536;
            end
        endcase
        if (kill) r = 0;
        return {8'hA0 + (kill ? 8'd2 : 8'd0) + 8'(r / 65536), 8'(r % 256), 8'((r / 256) % 256)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (RX_READY) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
        if (!ok) chk("rx_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
        send_byte(8'hCC);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        send_byte(f);
        chk("oper_a", 32'(A), 32'(a));
        chk("oper_b", 32'(B), 32'(b));
        chk("alu_fun", 32'(ALU_FUN), 32'(f[3:0]));
        chk("busy_exec", 32'(BUSY), 32'd1);
    endtask

    task automatic wait_check(input string tag, input logic [23:0] exp, input bit rnd);
        int n;
        n = 0;
        while ((tx_q.size() < 3 || BUSY) && n < 300) begin
            @(posedge CLK);
            #1;
            if (rnd) TX_READY = 1'($urandom_range(0, 1));
            n++;
        end
        TX_READY = 1'b1;
        if (n >= 300) chk({tag, "_timeout"}, 32'(n), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk({tag, "_count"}, 32'(tx_q.size()), 32'd3);
        if (tx_q.size() >= 3) begin
            chk({tag, "_status"}, 32'(tx_q[0]), 32'(exp[23:16]));
            chk({tag, "_lo"}, 32'(tx_q[1]), 32'(exp[15:8]));
            chk({tag, "_hi"}, 32'(tx_q[2]), 32'(exp[7:0]));
        end
        tx_q.delete();
    endtask

    initial begin
        int k;
        int n;
        logic [15:0] ra, rb;
        logic [7:0]  rf;
        logic [23:0] exp;

        // Reset state
        #2;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_rx_ready", 32'(RX_READY), 32'd0);
        chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_a", 32'(A), 32'd0);
        chk("rst_b", 32'(B), 32'd0);
        chk("rst_fun", 32'(ALU_FUN), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("idle_rx_ready", 32'(RX_READY), 32'd1);
        @(posedge CLK);
        #1;

        // 1) ADD with carry, plus latency FUN -> TX_VALID
        send_frame(16'hFFFF, 16'h0001, 8'h00);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (TX_VALID) begin
                k = i;
                break;
            end
        end
        chk("latency", 32'(k - 1), 32'(LAT + 1));
        @(posedge CLK);
        #1;
        wait_check("add", 24'hA10000, 1'b0);

        // 2) OR
        send_frame(16'h000F, 16'h00F0, 8'h05);
        wait_check("or", 24'hA0FF00, 1'b0);

        // 3) junk then CMP A>B
        send_byte(8'h12);
        chk("junk1_idle", 32'(BUSY), 32'd0);
        send_byte(8'h34);
        chk("junk2_idle", 32'(BUSY), 32'd0);
        send_frame(16'h0005, 16'h0003, 8'h09);
        wait_check("cmp", 24'hA00200, 1'b0);

        // Header value inside the frame is data; upper FUN nibble ignored
        send_frame(16'hCCCC, 16'hCCCC, 8'hF0);
        wait_check("hdr_data", ref_resp(32'hCCCC, 32'hCCCC, 0, 1'b0), 1'b0);

        // 4) stall during TX_LO
        exp = ref_resp(32'h1234, 32'h0F0F, 1, 1'b0);
        send_frame(16'h1234, 16'h0F0F, 8'h01);
        n = 0;
        while (!(TX_VALID && tx_q.size() == 1) && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("stall_reach_lo", 32'(n < 50), 32'd1);
        TX_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            chk("stall_valid", 32'(TX_VALID), 32'd1);
            chk("stall_data", 32'(TX_DATA), 32'(exp[15:8]));
        end
        chk("stall_no_extra", 32'(tx_q.size()), 32'd1);
        TX_READY = 1'b1;
        wait_check("stall", exp, 1'b0);

        // 5) reset in the middle of a frame
        send_byte(8'hCC);
        send_byte(8'h11);
        send_byte(8'h22);
        RST = 1'b1;
        #2;
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_a", 32'(A), 32'd0);
        chk("mid_rst_b", 32'(B), 32'd0);
        chk("mid_rst_rx_ready", 32'(RX_READY), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("post_rst_idle", 32'(BUSY), 32'd0);
        chk("post_rst_no_tx", 32'(tx_q.size()), 32'd0);
        send_frame(16'h0100, 16'h0001, 8'h0D);
        wait_check("after_rst", ref_resp(32'h0100, 32'h0001, 13, 1'b0), 1'b0);

        // 6) selected flag low at sample time
        flag_kill = 1'b1;
        send_frame(16'h8000, 16'h8000, 8'h00);
        wait_check("flag_err", 24'hA20000, 1'b0);
        flag_kill = 1'b0;

        // Randomized frames with junk and random TX back-pressure
        for (int t = 0; t < 30; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                send_byte(8'h5A);
                chk("rnd_junk_idle", 32'(BUSY), 32'd0);
            end
            send_frame(ra, rb, rf);
            wait_check("rnd", ref_resp(32'(ra), 32'(rb), 32'(rf[3:0]), 1'b0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
